// File: rtl/demux4_dist.sv
// demux4_dist: registered 1-to-4 data distributor.
//
// Accepts one word per cycle on a valid/ready input and routes it to one of
// four output channels, each backed by a one-entry holding register with its
// own valid/ready handshake. The channel is chosen by priority-decoded selects
// s0 > s1 > s2 > default channel 3.
//
// Parameters:
//   width            data word width in bits (>= 1)
//
// Ports:
//   clk              clock, all state updates on posedge
//   rst              synchronous active-high reset
//   din              input data word
//   s0, s1, s2       priority channel selects (none set -> channel 3)
//   din_vld          input word valid
//   din_rdy          input ready (combinational from selects and target state)
//   dout0..dout3     channel data registers
//   vld0..vld3       channel holds a valid word
//   rdy0..rdy3       channel consumer accepts this cycle
//   occ              registered count of occupied channels, 0..4
//
// Optional feature (define DEMUX4_DIST_CHK_EN, simulation only):
//   reports more than one select set while din_vld is high and ends the
//   simulation on the following posedge; drives din_rdy and vld0..3 to X
//   while any select or din_vld is X/Z.

module demux4_dist #(
    parameter int unsigned width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] din,
    input  logic             s0,
    input  logic             s1,
    input  logic             s2,
    input  logic             din_vld,
    output logic             din_rdy,
    output logic [width-1:0] dout0,
    output logic [width-1:0] dout1,
    output logic [width-1:0] dout2,
    output logic [width-1:0] dout3,
    output logic             vld0,
    output logic             vld1,
    output logic             vld2,
    output logic             vld3,
    input  logic             rdy0,
    input  logic             rdy1,
    input  logic             rdy2,
    input  logic             rdy3,
    output logic [2:0]       occ
);

    logic [1:0]       tgt;
    logic [3:0]       rdy_vec;
    logic [3:0]       vld_q;
    logic [3:0]       vld_nxt;
    logic [2:0]       occ_nxt;
    logic             din_rdy_core;
    logic             accept;
    logic [width-1:0] dout_q [4];

    assign rdy_vec = {rdy3, rdy2, rdy1, rdy0};

    // Priority decode of the selects.
    always_comb begin
        tgt = 2'd3;
        if (s0)      tgt = 2'd0;
        else if (s1) tgt = 2'd1;
        else if (s2) tgt = 2'd2;
    end

    // A channel can take a word when empty or when it drains in the same cycle.
    assign din_rdy_core = ~vld_q[tgt] | rdy_vec[tgt];
    assign accept       = din_vld & din_rdy_core;

    // Drain first, then let an accept set the target bit back, so a
    // simultaneous drain+accept keeps the channel valid.
    always_comb begin
        vld_nxt = vld_q & ~rdy_vec;
        if (accept) vld_nxt[tgt] = 1'b1;
        occ_nxt = {2'b00, vld_nxt[0]} + {2'b00, vld_nxt[1]}
                + {2'b00, vld_nxt[2]} + {2'b00, vld_nxt[3]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            occ   <= '0;
            for (int unsigned k = 0; k < 4; k++) dout_q[k] <= '0;
        end else begin
            vld_q <= vld_nxt;
            occ   <= occ_nxt;
            for (int unsigned k = 0; k < 4; k++) begin
                if (accept && (tgt == k[1:0])) dout_q[k] <= din;
            end
        end
    end

    assign dout0 = dout_q[0];
    assign dout1 = dout_q[1];
    assign dout2 = dout_q[2];
    assign dout3 = dout_q[3];

`ifdef DEMUX4_DIST_CHK_EN
    logic ctl_unknown = 1'b0;
    logic sel_err     = 1'b0;

    always @(s0, s1, s2, din_vld)
        ctl_unknown <= #0.2 $isunknown({s0, s1, s2, din_vld});

    always @(posedge clk) begin
        if (sel_err) $finish;
        if (din_vld === 1'b1 && (int'(s0) + int'(s1) + int'(s2)) > 1) begin
            $display("demux4_dist error, select signal above 1");
            sel_err <= 1'b1;
        end
    end

    assign din_rdy = ctl_unknown ? 1'bx : din_rdy_core;
    assign vld0    = ctl_unknown ? 1'bx : vld_q[0];
    assign vld1    = ctl_unknown ? 1'bx : vld_q[1];
    assign vld2    = ctl_unknown ? 1'bx : vld_q[2];
    assign vld3    = ctl_unknown ? 1'bx : vld_q[3];
`else
    assign din_rdy = din_rdy_core;
    assign vld0    = vld_q[0];
    assign vld1    = vld_q[1];
    assign vld2    = vld_q[2];
    assign vld3    = vld_q[3];
`endif

endmodule

// File: tb/tb_demux4_dist.sv
// Directed self-checking bench for demux4_dist (width = 16).
module tb_demux4_dist;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        s0, s1, s2;
    logic        din_vld;
    logic        din_rdy;
    logic [15:0] dout0, dout1, dout2, dout3;
    logic        vld0, vld1, vld2, vld3;
    logic        rdy0, rdy1, rdy2, rdy3;
    logic [2:0]  occ;

    int checks   = 0;
    int failures = 0;

    demux4_dist #(.width(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .s0      (s0),
        .s1      (s1),
        .s2      (s2),
        .din_vld (din_vld),
        .din_rdy (din_rdy),
        .dout0   (dout0),
        .dout1   (dout1),
        .dout2   (dout2),
        .dout3   (dout3),
        .vld0    (vld0),
        .vld1    (vld1),
        .vld2    (vld2),
        .vld3    (vld3),
        .rdy0    (rdy0),
        .rdy1    (rdy1),
        .rdy2    (rdy2),
        .rdy3    (rdy3),
        .occ     (occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one clock edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Select channel c via the priority selects (3 -> no select set).
    task automatic sel(input int c);
        s0 = (c == 0);
        s1 = (c == 1);
        s2 = (c == 2);
        #1;
    endtask

    initial begin
        rst = 1'b1; din = '0; din_vld = 1'b0;
        s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
        rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0; rdy3 = 1'b0;

        // Reset then idle
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_vld", {28'd0, vld3, vld2, vld1, vld0}, 32'h0);
        chk("rst_dout0", {16'd0, dout0}, 32'h0);
        chk("rst_dout1", {16'd0, dout1}, 32'h0);
        chk("rst_dout2", {16'd0, dout2}, 32'h0);
        chk("rst_dout3", {16'd0, dout3}, 32'h0);
        chk("rst_occ", {29'd0, occ}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            sel(c);
            chk($sformatf("rst_rdy_sel%0d", c), {31'd0, din_rdy}, 32'd1);
        end

        // Single word to channel 1, stalled consumer
        din = 16'h1234; sel(1); din_vld = 1'b1; #1;
        chk("ch1_accept_rdy", {31'd0, din_rdy}, 32'd1);
        tick();
        din_vld = 1'b0; #1;
        chk("ch1_dout", {16'd0, dout1}, 32'h1234);
        chk("ch1_vld", {31'd0, vld1}, 32'd1);
        chk("ch1_occ", {29'd0, occ}, 32'd1);
        chk("ch1_stall_rdy", {31'd0, din_rdy}, 32'd0);
        sel(0);
        chk("ch0_free_rdy", {31'd0, din_rdy}, 32'd1);
        sel(1); rdy1 = 1'b1; #1;
        chk("ch1_drain_rdy", {31'd0, din_rdy}, 32'd1);
        tick();
        rdy1 = 1'b0; #1;
        chk("ch1_drained_vld", {31'd0, vld1}, 32'd0);
        chk("ch1_hold_dout", {16'd0, dout1}, 32'h1234);
        chk("ch1_drained_occ", {29'd0, occ}, 32'd0);

        // Back-to-back stream to channel 3
        sel(3); rdy3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 16'hA000 + 16'(i); din_vld = 1'b1; #1;
            chk($sformatf("stream_rdy%0d", i), {31'd0, din_rdy}, 32'd1);
            tick();
            chk($sformatf("stream_vld%0d", i), {31'd0, vld3}, 32'd1);
            chk($sformatf("stream_dout%0d", i), {16'd0, dout3}, 32'hA000 + i);
            chk($sformatf("stream_occ%0d", i), {29'd0, occ}, 32'd1);
        end
        din_vld = 1'b0;
        tick();
        chk("stream_end_vld", {31'd0, vld3}, 32'd0);
        chk("stream_end_dout", {16'd0, dout3}, 32'hA003);
        rdy3 = 1'b0;

        // All selects set: priority picks channel 0
        s0 = 1'b1; s1 = 1'b1; s2 = 1'b1; din = 16'h00FF; din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        chk("prio_dout0", {16'd0, dout0}, 32'h00FF);
        chk("prio_vld0", {31'd0, vld0}, 32'd1);
        chk("prio_vld1", {31'd0, vld1}, 32'd0);
        chk("prio_vld2", {31'd0, vld2}, 32'd0);
        chk("prio_dout1", {16'd0, dout1}, 32'h1234);
        chk("prio_dout2", {16'd0, dout2}, 32'h0);
        chk("prio_occ", {29'd0, occ}, 32'd1);

        // Fill remaining channels with consumers stalled
        din_vld = 1'b1;
        sel(1); din = 16'h1111; tick();
        sel(2); din = 16'h2222; tick();
        sel(3); din = 16'h3333; tick();
        din_vld = 1'b0;
        chk("full_occ", {29'd0, occ}, 32'd4);
        chk("full_vld", {28'd0, vld3, vld2, vld1, vld0}, 32'hF);
        chk("full_dout3", {16'd0, dout3}, 32'h3333);
        for (int c = 0; c < 4; c++) begin
            sel(c);
            chk($sformatf("full_rdy_sel%0d", c), {31'd0, din_rdy}, 32'd0);
        end

        // Simultaneous drain and accept on channel 2
        sel(2); rdy2 = 1'b1; din = 16'hBEEF; din_vld = 1'b1; #1;
        chk("swap_rdy", {31'd0, din_rdy}, 32'd1);
        tick();
        din_vld = 1'b0; rdy2 = 1'b0;
        chk("swap_dout2", {16'd0, dout2}, 32'hBEEF);
        chk("swap_vld2", {31'd0, vld2}, 32'd1);
        chk("swap_occ", {29'd0, occ}, 32'd4);

        // Drain channel 3 -> occ = 3
        rdy3 = 1'b1; tick(); rdy3 = 1'b0;
        chk("pre_rst_occ", {29'd0, occ}, 32'd3);

        // Stalled input pending on channel 1, then reset
        sel(1); din = 16'hDEAD; din_vld = 1'b1; #1;
        chk("pend_rdy", {31'd0, din_rdy}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0; din_vld = 1'b0; #1;
        chk("mrst_vld", {28'd0, vld3, vld2, vld1, vld0}, 32'h0);
        chk("mrst_occ", {29'd0, occ}, 32'd0);
        chk("mrst_dout1", {16'd0, dout1}, 32'h0);
        chk("mrst_rdy", {31'd0, din_rdy}, 32'd1);
        tick();
        chk("mrst_no_deliver", {31'd0, vld1}, 32'd0);

        // Reset blocks accept to a free channel
        sel(3); din = 16'h5555; din_vld = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; din_vld = 1'b0; #1;
        chk("rst_block_vld3", {31'd0, vld3}, 32'd0);
        chk("rst_block_dout3", {16'd0, dout3}, 32'h0);
        chk("rst_block_occ", {29'd0, occ}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
